fq_rx_deframer: RTL and testbench

//  Receive end of the fair-queue output stream. Takes the merged 64-bit word stream (valid, no backpressure)
//  and recovers packet boundaries from the header length field.

---
 rtl/fq_pkg.sv | 17 +
 rtl/fq_rx_stats.sv | 34 +++
 rtl/fq_rx_deframer.sv | 144 ++++++++++++++
 tb/tb_fq_rx_deframer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// Shared definitions for the fair-queue receive path.
//   FQ_DATA_W / FQ_LEN_W : default stream word and header length widths
//   HDR_LEN_LSB/MSB      : position of the length field inside a header word
//   fq_rx_state_e        : deframer framing state
package fq_pkg;

  localparam int FQ_DATA_W   = 64;
  localparam int FQ_LEN_W    = 8;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = HDR_LEN_LSB + FQ_LEN_W - 1;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BODY = 1'b1
  } fq_rx_state_e;

endpackage

// File: rtl/fq_rx_stats.sv
// Wrapping statistics counters for the receive deframer.
//   clk, rst     : clock, asynchronous active-high reset
//   pkt_inc      : a packet completed (eop emitted)
//   word_inc     : a stream word was accepted
//   trunc_inc    : a packet was aborted on an idle gap
//   pkt_count, word_count, trunc_count : CNT_W counters, wrap modulo 2**CNT_W
module fq_rx_stats
  import fq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_inc,
  input  logic             word_inc,
  input  logic             trunc_inc,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] trunc_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count   <= '0;
      word_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (pkt_inc)   pkt_count   <= pkt_count + 1'b1;
      if (word_inc)  word_count  <= word_count + 1'b1;
      if (trunc_inc) trunc_count <= trunc_count + 1'b1;
    end
  end

endmodule

// File: rtl/fq_rx_deframer.sv
// Receive-side deframer for the merged fair-queue word stream.
// Recovers packet boundaries from the header length field (header bits
// [LEN_W-1:0] = total words including the header) and registers every
// accepted word with its framing one cycle later.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/in_data: stream input, no backpressure
//   out_valid/out_data/out_sop/out_eop/out_len : registered word + framing
//   out_abort       : pulse (out_valid=0) when a packet is cut by an idle gap
//   err_len_zero    : pulse with a header word carrying L==0
//   pkt_count/word_count/trunc_count : wrapping statistics
module fq_rx_deframer
  import fq_pkg::*;
#(
  parameter int DATA_W    = FQ_DATA_W,
  parameter int LEN_W     = FQ_LEN_W,
  parameter int CNT_W     = 32,
  parameter int GAP_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_abort,
  output logic              err_len_zero,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  trunc_count
);

  localparam int               GAP_W   = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIMIT);

  fq_rx_state_e     state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic [LEN_W-1:0] hdr_len;
  logic             sop_nxt, eop_nxt, abort_nxt, len_zero_nxt, len_load, pkt_inc;

  assign hdr_len = in_data[HDR_LEN_LSB +: LEN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      remaining <= '0;
      gap       <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      gap       <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    gap_nxt       = gap;
    sop_nxt       = 1'b0;
    eop_nxt       = 1'b0;
    abort_nxt     = 1'b0;
    len_zero_nxt  = 1'b0;
    len_load      = 1'b0;
    pkt_inc       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (in_valid) begin
          sop_nxt  = 1'b1;
          len_load = 1'b1;
          if (hdr_len == '0) begin
            // Malformed header: framed as a one-word packet but not counted.
            eop_nxt      = 1'b1;
            len_zero_nxt = 1'b1;
          end else if (hdr_len == LEN_W'(1)) begin
            eop_nxt = 1'b1;
            pkt_inc = 1'b1;
          end else begin
            remaining_nxt = hdr_len - 1'b1;
            gap_nxt       = '0;
            state_nxt     = RX_BODY;
          end
        end
      end
      RX_BODY: begin
        if (in_valid) begin
          // A word arriving on what would have been the expiring idle
          // cycle still belongs to the packet.
          gap_nxt       = '0;
          remaining_nxt = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            eop_nxt   = 1'b1;
            pkt_inc   = 1'b1;
            state_nxt = RX_IDLE;
          end
        end else if (gap + 1'b1 == GAP_MAX) begin
          abort_nxt = 1'b1;
          gap_nxt   = '0;
          state_nxt = RX_IDLE;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // ---- stage boundary: input word -> registered output word ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_len      <= '0;
      out_abort    <= 1'b0;
      err_len_zero <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      out_sop      <= sop_nxt;
      out_eop      <= eop_nxt;
      out_abort    <= abort_nxt;
      err_len_zero <= len_zero_nxt;
      if (in_valid) out_data <= in_data;
      if (len_load) out_len  <= hdr_len;
    end
  end

  fq_rx_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .pkt_inc    (pkt_inc),
    .word_inc   (in_valid),
    .trunc_inc  (abort_nxt),
    .pkt_count  (pkt_count),
    .word_count (word_count),
    .trunc_count(trunc_count)
  );

endmodule

// File: tb/tb_fq_rx_deframer.sv
// Scoreboard bench for fq_rx_deframer. Packets are described at packet
// level (length, intra-packet idle pattern, truncation point); the expected
// output words, aborts and statistics follow directly from that description.
module tb_fq_rx_deframer;

  localparam int DATA_W    = 64;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 32;
  localparam int GAP_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid, out_sop, out_eop, out_abort, err_len_zero;
  logic [DATA_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic [CNT_W-1:0]  pkt_count, word_count, trunc_count;

  fq_rx_deframer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_LIMIT(GAP_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_len(out_len), .out_abort(out_abort),
    .err_len_zero(err_len_zero), .pkt_count(pkt_count),
    .word_count(word_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                abort;
    logic [DATA_W-1:0] data;
    bit                sop;
    bit                eop;
    bit                err;
    logic [LEN_W-1:0]  len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_pkt = 0, exp_word = 0, exp_trunc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation for every presented word or abort.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_len_zero && out_abort) chk("err_and_abort_together", 1, 0);
      if (out_valid || out_abort) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.abort) begin
            chk("abort_flag", out_abort, 1);
            chk("abort_valid", out_valid, 0);
            chk("abort_sop_eop", {out_sop, out_eop}, 0);
            chk("abort_len_held", out_len, e.len);
            chk("abort_err", err_len_zero, 0);
          end else begin
            chk("word_abort", out_abort, 0);
            chk("word_data", out_data, e.data);
            chk("word_sop", out_sop, e.sop);
            chk("word_eop", out_eop, e.eop);
            chk("word_len", out_len, e.len);
            chk("word_err_len_zero", err_len_zero, e.err);
          end
        end
      end else if (err_len_zero) begin
        chk("err_without_valid", 1, 0);
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit sop, input bit eop,
                           input bit err, input logic [LEN_W-1:0] len);
    exp_t e;
    e.abort = 0; e.data = d; e.sop = sop; e.eop = eop; e.err = err; e.len = len;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(e);
    exp_word++;
  endtask

  // One packet of length L. After every gap_every-th word (0 = never) an
  // idle run of gap_len (< GAP_LIMIT) cycles is inserted. cut_at>0 sends
  // only that many words and then goes silent long enough to abort.
  task automatic send_packet(input int L, input int gap_every, input int gap_len, input int cut_at);
    int nwords, nsend;
    logic [DATA_W-1:0] d;
    nwords = (L == 0) ? 1 : L;
    nsend  = (cut_at > 0) ? cut_at : nwords;
    for (int i = 0; i < nsend; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[LEN_W-1:0] = LEN_W'(L);
      send_word(d, i == 0, (L <= 1) || (i == L - 1), L == 0, LEN_W'(L));
      if (gap_every > 0 && i < nsend - 1 && (i % gap_every) == gap_every - 1) idle(gap_len);
    end
    if (cut_at > 0) begin
      exp_t e;
      e.abort = 1; e.data = '0; e.sop = 0; e.eop = 0; e.err = 0; e.len = LEN_W'(L);
      sb.push_back(e);
      exp_trunc++;
      idle(GAP_LIMIT);
    end else if (L >= 1) begin
      exp_pkt++;
    end
  endtask

  task automatic check_counts(input string tag);
    idle(3);
    chk({tag, "_pkt_count"}, pkt_count, exp_pkt);
    chk({tag, "_word_count"}, word_count, exp_word);
    chk({tag, "_trunc_count"}, trunc_count, exp_trunc);
    chk({tag, "_scoreboard_drained"}, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_flags"}, {out_sop, out_eop, out_abort, err_len_zero}, 0);
    chk({tag, "_out_len"}, out_len, 0);
    chk({tag, "_counters"}, {pkt_count, word_count, trunc_count}, 0);
  endtask

  // Asserts rst between edges and checks outputs clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_pkt = 0; exp_word = 0; exp_trunc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    #1 rst = 1'b1;
    #2 check_all_zero("reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: L=3 back-to-back
    send_packet(3, 0, 0, 0);
    check_counts("t1_len3");

    // 2: L=1 then L=0
    send_packet(1, 0, 0, 0);
    send_packet(0, 0, 0, 0);
    check_counts("t2_len1_len0");

    // 3: short gap survives, full gap aborts, next word is a header
    send_packet(4, 2, 2, 0);
    send_packet(4, 0, 0, 2);
    send_packet(2, 0, 0, 0);
    check_counts("t3_gap");

    // 4: word lands on the cycle the gap would expire; repeated gaps
    send_packet(5, 1, GAP_LIMIT - 1, 0);
    check_counts("t4_coincident");

    // 5: reset after 2 of 5 words
    d = {$urandom, $urandom}; d[LEN_W-1:0] = 8'd5;
    send_word(d, 1, 0, 0, 8'd5);
    send_word({$urandom, $urandom}, 0, 0, 0, 8'd5);
    do_reset("t5_midpkt_reset");
    send_packet(3, 0, 0, 0);
    check_counts("t5_after_reset");

    // 6: L=2, L=2, L=255 back-to-back from a clean state
    do_reset("t6_pre_reset");
    send_packet(2, 0, 0, 0);
    send_packet(2, 0, 0, 0);
    send_packet(255, 0, 0, 0);
    check_counts("t6_b2b");
    chk("t6_word_count_259", word_count, 259);

    // Randomized packet mix
    for (int p = 0; p < 60; p++) begin
      int r, L, ge, gl, cut;
      r  = $urandom_range(0, 9);
      L  = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 12);
      ge = $urandom_range(0, 3);
      gl = $urandom_range(1, GAP_LIMIT - 1);
      cut = (L >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, L - 1) : 0;
      send_packet(L, ge, gl, cut);
      idle($urandom_range(0, 2));
    end
    check_counts("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
